// File: rtl/pdp8_fetch_decode.sv
// PDP-8 instruction fetch/decode unit.
// Fetches the word at PC_value, waits RD_LAT cycles for memory, decodes it
// into memory-reference / operate / IOT fields and pulses decode_valid.
// Optional build macro: IFD_IOT_FLAG_EN adds the iot_flag output (opcode 6).
module pdp8_fetch_decode #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  decode_valid,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_indirect,
    output logic [5:0]            mem_op,
    output logic                  op7_valid,
    output logic [8:0]            op7_bits
`ifdef IFD_IOT_FLAG_EN
    ,
    output logic                  iot_flag
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0] lat_cnt;
    logic       wait_done;
    logic       fetch_start;

    logic [2:0]            op;
    logic [5:0]            dec_mem_op;
    logic                  dec_indirect;
    logic [ADDR_WIDTH-1:0] dec_base;
    logic                  dec_op7_valid;
    logic [8:0]            dec_op7_bits;
    logic                  dec_iot;

    assign wait_done   = (lat_cnt == 3'(RD_LAT - 1));
    assign fetch_start = (next_state == S_FETCH);
    assign op          = ifu_rd_data[11:9];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; stall only matters in EXEC
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  next_state = S_WAIT;
            S_WAIT:   next_state = wait_done ? S_DECODE : S_WAIT;
            S_DECODE: next_state = S_EXEC;
            S_EXEC:   next_state = stall ? S_EXEC : S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // State-decoded strobes
    always_comb begin
        ifu_rd_req   = (state == S_FETCH);
        decode_valid = (state == S_DECODE);
    end

    // Read-latency counter, counts WAIT cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= '0;
        end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt + 3'd1;
        end else begin
            lat_cnt <= '0;
        end
    end

    // Read address is captured on entry to FETCH so it is valid alongside the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifu_rd_addr <= '0;
        end else if (fetch_start) begin
            ifu_rd_addr <= PC_value;
        end
    end

    // Combinational decode of the returning memory word
    always_comb begin
        dec_mem_op    = '0;
        dec_indirect  = 1'b0;
        dec_base      = '0;
        dec_op7_valid = 1'b0;
        dec_op7_bits  = '0;
        dec_iot       = 1'b0;
        case (op)
            3'd6: begin
`ifdef IFD_IOT_FLAG_EN
                dec_iot = 1'b1;
`endif
            end
            3'd7: begin
                dec_op7_valid = 1'b1;
                dec_op7_bits  = ifu_rd_data[8:0];
            end
            default: begin
                dec_mem_op   = 6'd1 << op;
                dec_indirect = ifu_rd_data[8];
                // Current page: high PC bits concatenated, no carry into them
                dec_base     = ifu_rd_data[7]
                             ? {ifu_rd_addr[ADDR_WIDTH-1:7], ifu_rd_data[6:0]}
                             : {{(ADDR_WIDTH-7){1'b0}}, ifu_rd_data[6:0]};
            end
        endcase
    end

    // Decode outputs register on the edge that ends the last WAIT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_op       <= '0;
            mem_indirect <= 1'b0;
            base_addr    <= '0;
            op7_valid    <= 1'b0;
            op7_bits     <= '0;
`ifdef IFD_IOT_FLAG_EN
            iot_flag     <= 1'b0;
`endif
        end else if (state == S_WAIT && wait_done) begin
            mem_op       <= dec_mem_op;
            mem_indirect <= dec_indirect;
            base_addr    <= dec_base;
            op7_valid    <= dec_op7_valid;
            op7_bits     <= dec_op7_bits;
`ifdef IFD_IOT_FLAG_EN
            iot_flag     <= dec_iot;
`endif
        end
    end

`ifndef IFD_IOT_FLAG_EN
    logic unused_iot;
    assign unused_iot = dec_iot;
`endif

endmodule

// File: tb/tb_pdp8_fetch_decode.sv
// Self-checking bench for pdp8_fetch_decode: one instance with RD_LAT=1 and
// one with RD_LAT=3, each fed by a small memory model that drives valid
// data only in the cycle the unit must sample it.
module tb_pdp8_fetch_decode;

    localparam logic [11:0] JUNK = 12'o5777;

    logic clk = 1'b0;
    logic reset_n;

    logic        stall1, req1, dv1, ind1, o7v1;
    logic [11:0] pc1, addr1, data1, base1, word1;
    logic [5:0]  mop1;
    logic [8:0]  o7b1;

    logic        stall3, req3, dv3, ind3, o7v3;
    logic [11:0] pc3, addr3, data3, base3, word3;
    logic [5:0]  mop3;
    logic [8:0]  o7b3;

`ifdef IFD_IOT_FLAG_EN
    logic iot1, iot3;
`else
    logic iot1 = 1'b0;
    logic iot3 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int d1 = -1;
    int d3 = -1;

    always #5 clk = ~clk;

    pdp8_fetch_decode #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .stall(stall1), .PC_value(pc1),
        .ifu_rd_req(req1), .ifu_rd_addr(addr1), .ifu_rd_data(data1),
        .decode_valid(dv1), .base_addr(base1), .mem_indirect(ind1),
        .mem_op(mop1), .op7_valid(o7v1), .op7_bits(o7b1)
`ifdef IFD_IOT_FLAG_EN
        , .iot_flag(iot1)
`endif
    );

    pdp8_fetch_decode #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .stall(stall3), .PC_value(pc3),
        .ifu_rd_req(req3), .ifu_rd_addr(addr3), .ifu_rd_data(data3),
        .decode_valid(dv3), .base_addr(base3), .mem_indirect(ind3),
        .mem_op(mop3), .op7_valid(o7v3), .op7_bits(o7b3)
`ifdef IFD_IOT_FLAG_EN
        , .iot_flag(iot3)
`endif
    );

    // Memory models: data valid only in the RD_LAT-th cycle after the request cycle
    always @(negedge clk) begin
        if (req1) d1 = 0;
        else if (d1 >= 0) d1 = d1 + 1;
        data1 = (d1 == 1) ? word1 : JUNK;
        if (req3) d3 = 0;
        else if (d3 >= 0) d3 = d3 + 1;
        data3 = (d3 == 3) ? word3 : JUNK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] pc;
        logic [11:0] data;
        int          stall_cyc;
        logic [5:0]  mop;
        logic        ind;
        logic [11:0] base;
        logic        o7v;
        logic [8:0]  o7b;
        logic        iot;
    } vec_t;

    vec_t vecs[8];
    vec_t v3[2];

    // Wait for decode_valid on dut1; returns negedges waited after the FETCH negedge
    task automatic wait_dec1(output int lat);
        bit found = 0;
        lat = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (dv1) begin
                found = 1;
                lat = t;
                break;
            end
        end
        chk("dv1_timeout", 32'(found), 32'd1);
    endtask

    task automatic chk_dec1(input vec_t v);
        chk("mem_op", 32'(mop1), 32'(v.mop));
        chk("mem_indirect", 32'(ind1), 32'(v.ind));
        chk("base_addr", 32'(base1), 32'(v.base));
        chk("op7_valid", 32'(o7v1), 32'(v.o7v));
        chk("op7_bits", 32'(o7b1), 32'(v.o7b));
`ifdef IFD_IOT_FLAG_EN
        chk("iot_flag", 32'(iot1), 32'(v.iot));
`endif
    endtask

    initial begin
        int lat;
        //            pc       data     stall mop        ind   base     o7v   o7b     iot
        vecs[0] = '{12'o0200, 12'o1045, 0, 6'b000010, 1'b0, 12'o0045, 1'b0, 9'o000, 1'b0};
        vecs[1] = '{12'o2345, 12'o5321, 0, 6'b100000, 1'b0, 12'o2321, 1'b0, 9'o000, 1'b0};
        vecs[2] = '{12'o0400, 12'o4777, 1, 6'b010000, 1'b1, 12'o0577, 1'b0, 9'o000, 1'b0};
        vecs[3] = '{12'o0000, 12'o7200, 5, 6'b000000, 1'b0, 12'o0000, 1'b1, 9'o200, 1'b0};
        vecs[4] = '{12'o0100, 12'o6001, 0, 6'b000000, 1'b0, 12'o0000, 1'b0, 9'o000, 1'b1};
        vecs[5] = '{12'o7777, 12'o0177, 2, 6'b000001, 1'b0, 12'o0177, 1'b0, 9'o000, 1'b0};
        vecs[6] = '{12'o1234, 12'o2600, 0, 6'b000100, 1'b1, 12'o1200, 1'b0, 9'o000, 1'b0};
        vecs[7] = '{12'o0050, 12'o7777, 0, 6'b000000, 1'b0, 12'o0000, 1'b1, 9'o777, 1'b0};
        v3[0]   = '{12'o0010, 12'o6001, 0, 6'b000000, 1'b0, 12'o0000, 1'b0, 9'o000, 1'b1};
        v3[1]   = '{12'o7600, 12'o3123, 0, 6'b001000, 1'b0, 12'o0123, 1'b0, 9'o000, 1'b0};

        reset_n = 1'b0;
        stall1 = 1'b1; stall3 = 1'b1;
        pc1 = vecs[0].pc; word1 = vecs[0].data;
        pc3 = 12'o0000; word3 = 12'o7000;
        data1 = JUNK; data3 = JUNK;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req1), 32'd0);
        chk("rst_dv", 32'(dv1), 32'd0);
        chk("rst_addr", 32'(addr1), 32'd0);
        chk("rst_dec", 32'({mop1, ind1, base1, o7v1, o7b1, iot1}), 32'd0);
        chk("rst_req3", 32'(req3), 32'd0);
        reset_n = 1'b1;

        // First fetch: IDLE -> FETCH on the first edge after release
        @(negedge clk);
        chk("first_req", 32'(req1), 32'd1);
        chk("first_addr", 32'(addr1), 32'(vecs[0].pc));

        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                // EXEC: stall held, no fetch may start
                for (int k = 0; k <= vecs[i].stall_cyc; k++) begin
                    @(negedge clk);
                    if (k == 0) chk("dv_pulse", 32'(dv1), 32'd0);
                    chk("stall_noreq", 32'(req1), 32'd0);
                end
                pc1 = vecs[i].pc; word1 = vecs[i].data; stall1 = 1'b0;
                @(negedge clk);
                chk("fetch_req", 32'(req1), 32'd1);
                chk("fetch_addr", 32'(addr1), 32'(vecs[i].pc));
            end
            wait_dec1(lat);
            chk("dec_latency", 32'(lat), 32'd1);
            chk_dec1(vecs[i]);
            stall1 = 1'b1;
        end

        // Reset asserted mid-WAIT while memory returns data
        @(negedge clk);
        pc1 = 12'o0300; word1 = 12'o1777; stall1 = 1'b0;
        @(negedge clk);
        chk("mw_req", 32'(req1), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mw_dv", 32'(dv1), 32'd0);
            chk("mw_outs", 32'({req1, addr1, mop1, ind1, base1, o7v1, o7b1, iot1}), 32'd0);
        end
        pc1 = 12'o0123; word1 = 12'o3123;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mw_req_after", 32'(req1), 32'd1);
        chk("mw_addr_after", 32'(addr1), 32'o0123);
        wait_dec1(lat);
        chk("mw_latency", 32'(lat), 32'd1);
        chk("mw_mem_op", 32'(mop1), 32'b001000);
        chk("mw_base", 32'(base1), 32'o0123);
        stall1 = 1'b1;

        // RD_LAT=3 instance: exact sample cycle and op 6 handling
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pc3 = v3[i].pc; word3 = v3[i].data; stall3 = 1'b0;
            @(negedge clk);
            chk("l3_req", 32'(req3), 32'd1);
            chk("l3_addr", 32'(addr3), 32'(v3[i].pc));
            stall3 = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("l3_wait_dv", 32'(dv3), 32'd0);
                chk("l3_wait_req", 32'(req3), 32'd0);
            end
            @(negedge clk);
            chk("l3_dv", 32'(dv3), 32'd1);
            chk("l3_mem_op", 32'(mop3), 32'(v3[i].mop));
            chk("l3_base", 32'(base3), 32'(v3[i].base));
            chk("l3_ind_op7", 32'({ind3, o7v3, o7b3}), 32'd0);
`ifdef IFD_IOT_FLAG_EN
            chk("l3_iot", 32'(iot3), 32'(v3[i].iot));
`endif
            @(negedge clk);
            chk("l3_dv_pulse", 32'(dv3), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
